irq_pending_ctrl: RTL
=====================

# irq_pending_ctrl

Four-channel interrupt capture and service sequencer that sits directly upstream of the 4-bit priority encoder. It edge-detects request lines into sticky pending bits and applies an enable mask. The masked vector drives the encoder's `I` input, and the block reads back the encoder's `Y`/`valid`. It runs a request/acknowledge handshake with the service logic, one interrupt at a time, highest index first.

## Interface
- `N_IRQ`, 4: number of request channels. Fixed at 4 to match the encoder width; no other value is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  4  request lines, synchronous to `clk`, level; a 0→1 transition is an event.
- `mask`  in  4  per-channel enable, 1 = enabled; combinational into `pend_vec`.
- `pend_vec`  out  4  `pending & mask`; connects to encoder `I`.
- `enc_y`  in  2  encoder `Y`.
- `enc_valid`  in  1  encoder `valid`.
- `irq_req`  out  1  service request, registered.
- `irq_id`  out  2  channel being serviced, registered; stable while `irq_req`=1.
- `irq_ack`  in  1  single-cycle acknowledge from the service logic.
- `pending`  out  4  raw pending register (status).
- `ovf`  out  4  sticky overrun flags.
- `ovf_clr`  in  1  clears all `ovf` bits.

## Operation
- Edge detect:
  - `irq_d` registers `irq_in` every cycle.
  - `rise = irq_in & ~irq_d`.
  - `irq_d` resets to 4'b1111, so lines already high at reset release do not generate events.
- Pending register:
  - On each edge, `pending[i]` is set if `rise[i]`.
  - `pending[i]` is cleared if the acknowledge-clear targets channel i.
  - If set and clear hit the same bit in the same cycle, set wins: the new event is retained.
- Overrun:
  - `ovf[i]` is set when `rise[i]` occurs while `pending[i]` is already 1 and the bit is not being cleared that cycle.
  - `ovf_clr` clears all bits. If a set and `ovf_clr` coincide, set wins.
- Masked pending bits stay pending and are not lost. Unmasking them later presents them to the encoder.
- FSM states: IDLE, SERVE, GAP.
  - IDLE: if `enc_valid`=1, load `irq_id<=enc_y`, set `irq_req<=1`, go to SERVE. Otherwise stay.
  - SERVE: hold `irq_id`/`irq_req`. On `irq_ack`=1, clear `pending[irq_id]`, drop `irq_req<=0`, go to GAP.
  - GAP: one cycle, unconditional return to IDLE. This lets the encoder settle on the cleared vector before the next sample.
- `irq_ack` is ignored outside SERVE.
- Changes to `mask` or new events during SERVE do not alter `irq_id`. The current service always completes.
- Priority is the encoder's: index 3 is highest. The block adds no arbitration of its own.

## Timing
- Reset (async assert, sync-free release): `pending`=0, `ovf`=0, `irq_req`=0, `irq_id`=0, state=IDLE, `irq_d`=4'b1111. Consequently `pend_vec`=0.
- Event latency, with `irq_in[i]` first sampled high at edge k:
  - `pending[i]`=1 after edge k; `pend_vec` updates combinationally.
  - FSM samples `enc_valid` at edge k+1; `irq_req`=1 after edge k+1 (2 cycles).
- Ack latency:
  - `irq_ack` sampled at edge m: `irq_req`=0 and the `pending` bit clears after edge m.
  - GAP occupies cycle m+1.
  - The next `irq_req` can rise no earlier than after edge m+2, giving a 2-cycle minimum gap between services.
- Back-to-back service rate: 1 interrupt per 3 cycles minimum when `irq_ack` is returned the cycle after `irq_req` rises.
- Reset asserted mid-SERVE aborts the service immediately. No ack is required afterwards.

## Test plan
- Reset with `irq_in`=4'b0101 held high, then release:
  - Required: `pending`=0, `irq_req`=0.
  - Then drop the lines and pulse `irq_in[0]`: `pending`=4'b0001, and `irq_req`=1 with `irq_id`=0 two cycles after the rise.
- Single event on channel 2 with `mask`=4'b1111:
  - Required: `pend_vec`=4'b0100, `irq_id`=2.
  - After `irq_ack`: `pending`=0 and `irq_req`=0 the next cycle.
- Simultaneous rises on channels 1 and 3, with ack returned each time:
  - Required: serviced as `irq_id`=3, then `irq_id`=1, with one GAP cycle between.
  - Final `pending`=0.
- `mask`=4'b0111 with events on channels 3 and 0:
  - Required: only channel 0 is serviced; `pending`=4'b1000 remains.
  - Setting `mask`=4'b1111 then produces service with `irq_id`=3.
- Second rise on channel 1 while `pending[1]`=1 (in SERVE for channel 1):
  - Required: `ovf`=4'b0010.
  - Rise coinciding with the ack: `pending[1]` stays 1 and `ovf[1]` is unchanged.
  - `ovf_clr` clears `ovf` to 0.
- Assert `rst_n`=0 while in SERVE with `irq_id`=2:
  - Required: `irq_req`=0, `pending`=0, `ovf`=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: four-channel interrupt capture and service sequencer.
// Rising edges on irq_in set sticky pending bits. The enabled subset is
// presented to an external priority encoder, and the encoder's choice is
// serviced one at a time through an irq_req/irq_ack handshake.
module irq_pending_ctrl #(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pend_vec,
    input  logic [1:0]       enc_y,
    input  logic             enc_valid,
    output logic             irq_req,
    output logic [1:0]       irq_id,
    input  logic             irq_ack,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] ovf,
    input  logic             ovf_clr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [N_IRQ-1:0] irq_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] ovf_set;
    logic             ack_hit;

    assign rise     = irq_in & ~irq_d;
    assign pend_vec = pending & mask;
    assign ack_hit  = (state == SERVE) && irq_ack;

    // Decode the acknowledge into a one-hot clear of the channel being serviced.
    always_comb begin
        clr_vec = '0;
        if (ack_hit) begin
            clr_vec[irq_id] = 1'b1;
        end
    end

    // A new edge on a channel that is still pending (and not being retired now) is an overrun.
    always_comb begin
        ovf_set = rise & pending & ~clr_vec;
    end

    // Previous-cycle copy of the request lines; starts all-ones so lines high at reset release are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d <= '1;
        end else begin
            irq_d <= irq_in;
        end
    end

    // Sticky pending bits: a fresh edge beats a simultaneous acknowledge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | rise;
        end
    end

    // Sticky overrun flags: a new overrun beats a simultaneous bulk clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else if (ovf_clr) begin
            ovf <= ovf_set;
        end else begin
            ovf <= ovf | ovf_set;
        end
    end

    // Next-state logic for the service sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enc_valid) state_next = SERVE;
            SERVE:   if (irq_ack) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the registered request/id, which are frozen for the whole service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= 2'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && enc_valid) begin
                irq_id  <= enc_y;
                irq_req <= 1'b1;
            end else if (ack_hit) begin
                irq_req <= 1'b0;
            end
        end
    end

endmodule
